tcp_client: RTL
===============

# tcp_client

Active-open TCP connection controller: the initiating peer to the passive `tcp_server`. It issues SYN on request, completes the three-way handshake, tracks sequence/acknowledge numbers for control segments, and performs both active close (FIN_WAIT path) and passive close (CLOSE_WAIT path), with retransmission on timeout. Payload transfer is out of scope; the block emits control segments only, through a one-entry valid/ready transmit slot, to the packet formatter.

## Interface
- `RTO_CYCLES`, 1000: retransmission timeout in clock cycles.
- `MAX_RETRIES`, 3: retransmissions of a segment before the connection is aborted.
- `TIME_WAIT_CYCLES`, 2000: dwell time in TIME_WAIT.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `connect_in` in 1: level; request active open, honoured in CLOSED.
- `close_in` in 1: level; request close, honoured in ESTABLISHED/CLOSE_WAIT.
- `abort_in` in 1: level; request RST abort, honoured in any non-CLOSED state.
- `loc_port_in` / `rem_port_in` in 16: ports, latched on connect.
- `iss_in` in 32: initial send sequence, latched on connect.
- `rx_vld_in` in 1, `rx_rdy_out` out 1: receive segment handshake.
- `SYN_in`, `ACK_in`, `FIN_in`, `RST_in` in 1: received flags.
- `seq_number_in`, `ack_number_in` in 32; `src_port_in`, `dst_port_in` in 16: received header fields.
- `tx_vld_out` out 1, `tx_rdy_in` in 1: transmit segment handshake.
- `SYN_out`, `ACK_out`, `FIN_out`, `RST_out` out 1; `seq_number_out`, `ack_number_out` out 32; `src_port_out`, `dst_port_out` out 16: transmitted header.
- `state_out` out 3: current state encoding.
- `established_out` out 1: high in ESTABLISHED.
- `err_out` out 1: one-cycle pulse on retry exhaustion or received RST.

## Operation
- States: CLOSED, SYN_SENT, ESTABLISHED, FIN_WAIT_1, FIN_WAIT_2, TIME_WAIT, CLOSE_WAIT, LAST_ACK.
- Registers: `snd_nxt`, `rcv_nxt` (32-bit, wrap mod 2^32); SYN and FIN each consume one sequence number.
- Rx acceptance: only when `rx_vld_in && rx_rdy_out`, and only if `dst_port_in==loc_port` and `src_port_in==rem_port`; otherwise dropped without a state change.
- Priority per cycle: abort > rx segment > timer expiry > connect/close. None of them is acted upon while the tx slot is occupied.
- CLOSED + connect: latch ports/iss; emit SYN with seq=iss, ack=0; set `snd_nxt=iss+1`; go to SYN_SENT.
- SYN_SENT + SYN&ACK with ack==snd_nxt: set `rcv_nxt=seq+1`; emit ACK (seq=snd_nxt, ack=rcv_nxt); go to ESTABLISHED. RST&ACK with ack==snd_nxt goes to CLOSED with err pulse. Anything else is ignored.
- ESTABLISHED + close: emit FIN|ACK (seq=snd_nxt, ack=rcv_nxt); `snd_nxt++`; go to FIN_WAIT_1.
- ESTABLISHED + FIN with seq==rcv_nxt: `rcv_nxt++`; emit ACK; go to CLOSE_WAIT. RST with seq==rcv_nxt goes to CLOSED with err pulse. Bare ACK segments are ignored.
- FIN_WAIT_1:
  - ACK with ack==snd_nxt and no FIN goes to FIN_WAIT_2.
  - FIN&ACK with ack==snd_nxt and seq==rcv_nxt: `rcv_nxt++`; emit ACK; go to TIME_WAIT.
  - FIN without a valid ack is ignored (no simultaneous-close state).
- FIN_WAIT_2 + FIN with seq==rcv_nxt: `rcv_nxt++`; emit ACK; go to TIME_WAIT.
- TIME_WAIT: after TIME_WAIT_CYCLES go to CLOSED. A retransmitted FIN (seq==rcv_nxt-1) re-emits the ACK and restarts the count.
- CLOSE_WAIT + close: emit FIN|ACK; `snd_nxt++`; go to LAST_ACK.
- LAST_ACK + ACK with ack==snd_nxt: go to CLOSED.
- Abort: emit RST (seq=snd_nxt, ack=0); go to CLOSED; no err pulse.
- Retransmission (SYN_SENT, FIN_WAIT_1, LAST_ACK): on RTO expiry re-emit the last SYN/FIN segment with identical fields and increment the retry count. When the count would exceed MAX_RETRIES: go to CLOSED with err pulse, emitting nothing.
- Retry count clears on every state change.

## Timing
- Reset values: every output 0, `state_out`=CLOSED, all registers 0.
- Response latency: `tx_vld_out` rises the cycle after the triggering rx handshake, request sample, or timer expiry.
- Tx handshake: fields are held stable and `tx_vld_out` stays high until `tx_rdy_in`; the slot frees in the handshake cycle.
- `rx_rdy_out = !tx_vld_out`, so back-to-back segments stall while the slot is full.
- State transitions happen in the same edge as the segment is queued; `state_out` updates together with `tx_vld_out`.
- RTO counter: reloads to RTO_CYCLES when a retransmittable segment is queued, and expires at 0 only when the slot is free. Segment acceptance stops it.
- Reset mid-operation: returns to CLOSED immediately, and any pending tx segment is discarded.

## Structure
- Package `tcp_client_operations`: `tcp_client_state_t` enum (3-bit) and the flag-combination constants.
- Sub-module `tcp_client_timer`: down-counter shared for RTO and TIME_WAIT, with load/value/expire ports.
- Top level holds the FSM, the sequence registers, and the tx slot register.

## Test plan
- Handshake: connect with iss=0x100, rem=80; respond SYN&ACK seq=0x500 ack=0x101. Expect SYN seq 0x100, then ACK seq 0x101 ack 0x501, then ESTABLISHED.
- Active close: from the previous state, close → FIN|ACK seq 0x101; then ACK ack=0x102 → FIN_WAIT_2; then FIN seq=0x501 → ACK ack 0x502, TIME_WAIT, and CLOSED after 2000 cycles.
- Retry exhaustion: connect with no reply. Expect 4 identical SYNs spaced 1000 cycles apart, then CLOSED with a one-cycle `err_out`.
- Wrap: iss=0xFFFFFFFF. Expect SYN seq 0xFFFFFFFF, and SYN&ACK ack=0x0 accepted.
- Filtering and backpressure:
  - A segment with the wrong dst_port is ignored.
  - With `tx_rdy_in` held low, fields stay stable, `rx_rdy_out` stays 0, and no retransmit is queued.
- Abort and reset: abort in ESTABLISHED → RST seq=snd_nxt, then CLOSED. Asserting `rst` in FIN_WAIT_1 clears all outputs asynchronously.

Source files
------------

// File: rtl/tcp_client_pkg.sv
// Shared types for the active-open TCP client: FSM state encoding, header flag
// combinations and the transmit-slot segment payload.
package tcp_client_operations;

    localparam int unsigned SEQ_W  = 32;
    localparam int unsigned PORT_W = 16;

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_SYN_SENT    = 3'd1,
        ST_ESTABLISHED = 3'd2,
        ST_FIN_WAIT_1  = 3'd3,
        ST_FIN_WAIT_2  = 3'd4,
        ST_TIME_WAIT   = 3'd5,
        ST_CLOSE_WAIT  = 3'd6,
        ST_LAST_ACK    = 3'd7
    } tcp_client_state_t;

    typedef struct packed {
        logic syn;
        logic ack;
        logic fin;
        logic rst;
    } tcp_flags_t;

    localparam tcp_flags_t FLAGS_SYN     = 4'b1000;
    localparam tcp_flags_t FLAGS_ACK     = 4'b0100;
    localparam tcp_flags_t FLAGS_FIN_ACK = 4'b0110;
    localparam tcp_flags_t FLAGS_RST     = 4'b0001;

    typedef struct packed {
        tcp_flags_t          flags;
        logic [SEQ_W-1:0]    seq;
        logic [SEQ_W-1:0]    ack;
        logic [PORT_W-1:0]   src_port;
        logic [PORT_W-1:0]   dst_port;
    } tcp_seg_t;

endpackage

// File: rtl/tcp_client_timer.sv
// Down-counter shared by retransmission and TIME_WAIT; expiry lands value_i
// cycles after load and is deferred while hold_i (tx slot busy) is high.
module tcp_client_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             stop_i,
    input  logic             hold_i,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = value_i - CNT_W'(1);
            run_d = 1'b1;
        end else if (stop_i) begin
            run_d = 1'b0;
        end else if (run_q) begin
            if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
            else if (!hold_i) run_d = 1'b0;
        end
    end

    assign expire_c = run_q && (cnt_q == '0) && !hold_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/tcp_client.sv
// Active-open TCP control-segment FSM: handshake, active/passive close, abort
// and retransmission, emitting segments through a one-entry tx slot.
module tcp_client
    import tcp_client_operations::*;
#(
    parameter int unsigned RTO_CYCLES       = 1000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned TIME_WAIT_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              connect_in,
    input  logic              close_in,
    input  logic              abort_in,
    input  logic [PORT_W-1:0] loc_port_in,
    input  logic [PORT_W-1:0] rem_port_in,
    input  logic [SEQ_W-1:0]  iss_in,
    input  logic              rx_vld_in,
    output logic              rx_rdy_out,
    input  logic              SYN_in,
    input  logic              ACK_in,
    input  logic              FIN_in,
    input  logic              RST_in,
    input  logic [SEQ_W-1:0]  seq_number_in,
    input  logic [SEQ_W-1:0]  ack_number_in,
    input  logic [PORT_W-1:0] src_port_in,
    input  logic [PORT_W-1:0] dst_port_in,
    output logic              tx_vld_out,
    input  logic              tx_rdy_in,
    output logic              SYN_out,
    output logic              ACK_out,
    output logic              FIN_out,
    output logic              RST_out,
    output logic [SEQ_W-1:0]  seq_number_out,
    output logic [SEQ_W-1:0]  ack_number_out,
    output logic [PORT_W-1:0] src_port_out,
    output logic [PORT_W-1:0] dst_port_out,
    output logic [2:0]        state_out,
    output logic              established_out,
    output logic              err_out
);

    localparam int unsigned RETRY_W = 8;

    tcp_client_state_t   state_q, state_d;
    logic [SEQ_W-1:0]    snd_nxt_q, snd_nxt_d, rcv_nxt_q, rcv_nxt_d;
    logic [PORT_W-1:0]   loc_port_q, loc_port_d, rem_port_q, rem_port_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    tcp_seg_t            seg_q, seg_d;
    logic                tx_vld_q, tx_vld_d;
    logic                err_q, err_d;
    logic                tmr_load, tmr_stop, tmr_exp, acted, rx_acc;
    logic [SEQ_W-1:0]    tmr_val, seq_inc;

    function automatic tcp_seg_t mk_seg(input tcp_flags_t f, input logic [SEQ_W-1:0] s,
                                        input logic [SEQ_W-1:0] a,
                                        input logic [PORT_W-1:0] sp,
                                        input logic [PORT_W-1:0] dp);
        tcp_seg_t r;
        r.flags    = f;
        r.seq      = s;
        r.ack      = a;
        r.src_port = sp;
        r.dst_port = dp;
        return r;
    endfunction

    assign rx_acc  = rx_vld_in && !tx_vld_q && (dst_port_in == loc_port_q)
                     && (src_port_in == rem_port_q);
    assign seq_inc = seq_number_in + SEQ_W'(1);

    always_comb begin
        state_d    = state_q;
        snd_nxt_d  = snd_nxt_q;
        rcv_nxt_d  = rcv_nxt_q;
        loc_port_d = loc_port_q;
        rem_port_d = rem_port_q;
        retry_d    = retry_q;
        seg_d      = seg_q;
        tx_vld_d   = tx_vld_q;
        err_d      = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = SEQ_W'(RTO_CYCLES);
        acted      = 1'b0;
        if (tx_vld_q && tx_rdy_in) tx_vld_d = 1'b0;
        if (!tx_vld_q) begin
            if (abort_in && state_q != ST_CLOSED) begin
                seg_d    = mk_seg(FLAGS_RST, snd_nxt_q, '0, loc_port_q, rem_port_q);
                tx_vld_d = 1'b1;
                state_d  = ST_CLOSED;
            end else begin
                // Received segments: each branch that acts claims the cycle.
                if (rx_acc) begin
                    case (state_q)
                        ST_SYN_SENT: if (ACK_in && ack_number_in == snd_nxt_q) begin
                            if (RST_in) begin
                                state_d = ST_CLOSED;
                                err_d   = 1'b1;
                                acted   = 1'b1;
                            end else if (SYN_in) begin
                                rcv_nxt_d = seq_inc;
                                seg_d     = mk_seg(FLAGS_ACK, snd_nxt_q, seq_inc, loc_port_q, rem_port_q);
                                tx_vld_d  = 1'b1;
                                state_d   = ST_ESTABLISHED;
                                acted     = 1'b1;
                            end
                        end
                        ST_ESTABLISHED: if (seq_number_in == rcv_nxt_q) begin
                            if (RST_in) begin
                                state_d = ST_CLOSED;
                                err_d   = 1'b1;
                                acted   = 1'b1;
                            end else if (FIN_in) begin
                                rcv_nxt_d = seq_inc;
                                seg_d     = mk_seg(FLAGS_ACK, snd_nxt_q, seq_inc, loc_port_q, rem_port_q);
                                tx_vld_d  = 1'b1;
                                state_d   = ST_CLOSE_WAIT;
                                acted     = 1'b1;
                            end
                        end
                        ST_FIN_WAIT_1: if (ACK_in && !RST_in && ack_number_in == snd_nxt_q) begin
                            if (!FIN_in) begin
                                state_d = ST_FIN_WAIT_2;
                                acted   = 1'b1;
                            end else if (seq_number_in == rcv_nxt_q) begin
                                rcv_nxt_d = seq_inc;
                                seg_d     = mk_seg(FLAGS_ACK, snd_nxt_q, seq_inc, loc_port_q, rem_port_q);
                                tx_vld_d  = 1'b1;
                                state_d   = ST_TIME_WAIT;
                                tmr_load  = 1'b1;
                                tmr_val   = SEQ_W'(TIME_WAIT_CYCLES);
                                acted     = 1'b1;
                            end
                        end
                        ST_FIN_WAIT_2: if (FIN_in && seq_number_in == rcv_nxt_q) begin
                            rcv_nxt_d = seq_inc;
                            seg_d     = mk_seg(FLAGS_ACK, snd_nxt_q, seq_inc, loc_port_q, rem_port_q);
                            tx_vld_d  = 1'b1;
                            state_d   = ST_TIME_WAIT;
                            tmr_load  = 1'b1;
                            tmr_val   = SEQ_W'(TIME_WAIT_CYCLES);
                            acted     = 1'b1;
                        end
                        ST_TIME_WAIT: if (FIN_in && seq_number_in == rcv_nxt_q - SEQ_W'(1)) begin
                            seg_d    = mk_seg(FLAGS_ACK, snd_nxt_q, rcv_nxt_q, loc_port_q, rem_port_q);
                            tx_vld_d = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = SEQ_W'(TIME_WAIT_CYCLES);
                            acted    = 1'b1;
                        end
                        ST_LAST_ACK: if (ACK_in && ack_number_in == snd_nxt_q) begin
                            state_d = ST_CLOSED;
                            acted   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Timer expiry: the slot still holds the last SYN/FIN, so a resend just revalidates it.
                if (!acted && tmr_exp) begin
                    acted = 1'b1;
                    case (state_q)
                        ST_SYN_SENT, ST_FIN_WAIT_1, ST_LAST_ACK: begin
                            if (retry_q >= RETRY_W'(MAX_RETRIES)) begin
                                state_d = ST_CLOSED;
                                err_d   = 1'b1;
                            end else begin
                                retry_d  = retry_q + RETRY_W'(1);
                                tx_vld_d = 1'b1;
                                tmr_load = 1'b1;
                            end
                        end
                        ST_TIME_WAIT: state_d = ST_CLOSED;
                        default: ;
                    endcase
                end
                if (!acted) begin
                    if (connect_in && state_q == ST_CLOSED) begin
                        loc_port_d = loc_port_in;
                        rem_port_d = rem_port_in;
                        snd_nxt_d  = iss_in + SEQ_W'(1);
                        rcv_nxt_d  = '0;
                        seg_d      = mk_seg(FLAGS_SYN, iss_in, '0, loc_port_in, rem_port_in);
                        tx_vld_d   = 1'b1;
                        state_d    = ST_SYN_SENT;
                        tmr_load   = 1'b1;
                    end else if (close_in && (state_q == ST_ESTABLISHED || state_q == ST_CLOSE_WAIT)) begin
                        seg_d     = mk_seg(FLAGS_FIN_ACK, snd_nxt_q, rcv_nxt_q, loc_port_q, rem_port_q);
                        snd_nxt_d = snd_nxt_q + SEQ_W'(1);
                        tx_vld_d  = 1'b1;
                        state_d   = (state_q == ST_ESTABLISHED) ? ST_FIN_WAIT_1 : ST_LAST_ACK;
                        tmr_load  = 1'b1;
                    end
                end
            end
        end
        tmr_stop = (state_d != state_q);
        if (state_d != state_q) retry_d = '0;
    end

    tcp_client_timer #(.CNT_W(SEQ_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .value_i  (tmr_val),
        .stop_i   (tmr_stop),
        .hold_i   (tx_vld_q),
        .expire_c (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLOSED;
            snd_nxt_q  <= '0;
            rcv_nxt_q  <= '0;
            loc_port_q <= '0;
            rem_port_q <= '0;
            retry_q    <= '0;
            seg_q      <= '0;
            tx_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snd_nxt_q  <= snd_nxt_d;
            rcv_nxt_q  <= rcv_nxt_d;
            loc_port_q <= loc_port_d;
            rem_port_q <= rem_port_d;
            retry_q    <= retry_d;
            seg_q      <= seg_d;
            tx_vld_q   <= tx_vld_d;
            err_q      <= err_d;
        end
    end

    assign rx_rdy_out      = !tx_vld_q;
    assign tx_vld_out      = tx_vld_q;
    assign SYN_out         = seg_q.flags.syn;
    assign ACK_out         = seg_q.flags.ack;
    assign FIN_out         = seg_q.flags.fin;
    assign RST_out         = seg_q.flags.rst;
    assign seq_number_out  = seg_q.seq;
    assign ack_number_out  = seg_q.ack;
    assign src_port_out    = seg_q.src_port;
    assign dst_port_out    = seg_q.dst_port;
    assign state_out       = state_q;
    assign established_out = (state_q == ST_ESTABLISHED);
    assign err_out         = err_q;

endmodule
